// File: rtl/fifo_v3.sv
// Synchronous FIFO with a registered occupancy count, optional fall-through and synchronous flush.
// Pointers wrap at DEPTH-1, so non-power-of-2 depths are handled.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned CntW = ADDR_DEPTH + 1;

   logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);

   always_comb begin
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      data_o   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;

      // Fall-through bypass: an entry pushed and popped while empty never touches storage.
      if (FALL_THROUGH && empty_o) begin
         data_o = data_i;
         if (push_i && pop_i) begin
            do_push = 1'b0;
            do_pop  = 1'b0;
         end
      end

      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - 1'b1;
      end

      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/rr_resp_demux.sv
// Response return path for the round-robin arbiter: records each granted index and steers
// in-order slave responses back to the master that won, popping on the last beat.
module rr_resp_demux #(
   parameter int unsigned NumOut    = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxTrans  = 4,
   parameter int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
   parameter int unsigned CntWidth  = (MaxTrans > 1) ? $clog2(MaxTrans) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 req_hs_i,
   input  logic [IdxWidth-1:0]  req_idx_i,
   output logic                 full_o,
   input  logic                 rsp_valid_i,
   output logic                 rsp_ready_o,
   input  logic                 rsp_last_i,
   input  logic [DataWidth-1:0] rsp_data_i,
   output logic [NumOut-1:0]    rsp_valid_o,
   input  logic [NumOut-1:0]    rsp_ready_i,
   output logic [DataWidth-1:0] rsp_data_o,
   output logic                 rsp_last_o,
   output logic [IdxWidth-1:0]  rsp_idx_o,
   output logic                 busy_o
);

   typedef logic [IdxWidth-1:0] idx_t;

   idx_t fifo_head;
   idx_t head;
   logic fifo_empty;
   logic push, pop;

   assign push = req_hs_i & ~full_o;
   assign pop  = rsp_valid_i & rsp_ready_o & rsp_last_i;

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (IdxWidth),
      .DEPTH        (MaxTrans)
   ) u_idx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .full_o  (full_o),
      .empty_o (fifo_empty),
      .data_i  (req_idx_i),
      .push_i  (push),
      .data_o  (fifo_head),
      .pop_i   (pop)
   );

   assign busy_o = ~fifo_empty;

   // With a single master the stored index carries no information; keep routing pinned to 0.
   if (NumOut == 1) begin : g_single
      assign head = '0;
   end else begin : g_multi
      assign head = fifo_head;
   end

   always_comb begin
      rsp_valid_o = '0;
      rsp_ready_o = 1'b0;
      rsp_idx_o   = '0;
      if (busy_o) begin
         rsp_valid_o[head] = rsp_valid_i;
         rsp_ready_o       = rsp_ready_i[head];
         rsp_idx_o         = head;
      end
   end

   assign rsp_data_o = rsp_data_i;
   assign rsp_last_o = rsp_last_i;

`ifndef SYNTHESIS
   a_valid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(rsp_valid_o));

   a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_hs_i |-> !full_o)
      else $fatal(1, "request handshake while index fifo is full");

   a_rsp_when_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(rsp_valid_i && !busy_o))
      else $warning("response valid with no outstanding request");

   a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      (rsp_valid_i && !rsp_ready_o) |=> rsp_valid_i);
`endif

endmodule

// File: tb/tb_rr_resp_demux.sv
// Directed bench for rr_resp_demux: ordering, full/wrap, multi-beat, empty stall and flush.
module tb_rr_resp_demux;

   localparam int unsigned NumOut    = 4;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned MaxTrans  = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 flush_i;
   logic                 req_hs_i;
   logic [1:0]           req_idx_i;
   logic                 full_o;
   logic                 rsp_valid_i;
   logic                 rsp_ready_o;
   logic                 rsp_last_i;
   logic [DataWidth-1:0] rsp_data_i;
   logic [NumOut-1:0]    rsp_valid_o;
   logic [NumOut-1:0]    rsp_ready_i;
   logic [DataWidth-1:0] rsp_data_o;
   logic                 rsp_last_o;
   logic [1:0]           rsp_idx_o;
   logic                 busy_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   rr_resp_demux #(
      .NumOut    (NumOut),
      .DataWidth (DataWidth),
      .MaxTrans  (MaxTrans)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .req_hs_i    (req_hs_i),
      .req_idx_i   (req_idx_i),
      .full_o      (full_o),
      .rsp_valid_i (rsp_valid_i),
      .rsp_ready_o (rsp_ready_o),
      .rsp_last_i  (rsp_last_i),
      .rsp_data_i  (rsp_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_last_o  (rsp_last_o),
      .rsp_idx_o   (rsp_idx_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [1:0] fill_idx [4];
      logic [1:0] seq [11];
      logic [1:0] drain [4];
      logic [3:0] exp_v;

      fill_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
      drain    = '{2'd3, 2'd0, 2'd1, 2'd2};
      for (int i = 0; i < 11; i++) seq[i] = 2'((i * 3 + 1) % 4);

      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      req_hs_i    = 1'b0;
      req_idx_i   = '0;
      rsp_valid_i = 1'b0;
      rsp_last_i  = 1'b0;
      rsp_data_i  = 32'h0000_00a5;
      rsp_ready_i = '0;
      #3;
      chk("rst_full", full_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", rsp_ready_o, 0);
      chk("rst_valid", rsp_valid_o, 0);
      chk("rst_idx", rsp_idx_o, 0);
      chk("rst_data_pass", rsp_data_o, 32'h0000_00a5);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
      chk("idle_busy", busy_o, 0);
      chk("idle_full", full_o, 0);
      step();

      // In-order single-beat routing
      req_hs_i = 1'b1; req_idx_i = 2'd2; #1;
      chk("push0_busy_pre", busy_o, 0);
      step();
      req_idx_i = 2'd0; #1;
      chk("push1_busy", busy_o, 1);
      chk("push1_head", rsp_idx_o, 2);
      step();
      req_idx_i = 2'd3; #1;
      step();
      req_hs_i = 1'b0; rsp_ready_i = 4'hf;
      rsp_valid_i = 1'b1; rsp_last_i = 1'b1; rsp_data_i = 32'hd000_0000; #1;
      chk("d0_valid", rsp_valid_o, 4'b0100);
      chk("d0_ready", rsp_ready_o, 1);
      chk("d0_data", rsp_data_o, 32'hd000_0000);
      step();
      rsp_data_i = 32'hd000_0001; #1;
      chk("d1_valid", rsp_valid_o, 4'b0001);
      step();
      rsp_data_i = 32'hd000_0002; #1;
      chk("d2_valid", rsp_valid_o, 4'b1000);
      step();
      rsp_valid_i = 1'b0; #1;
      chk("d_done_busy", busy_o, 0);
      chk("d_done_ready", rsp_ready_o, 0);
      step();

      // Fill to full, pop at full, push+pop at count 3
      req_hs_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_idx_i = fill_idx[i]; #1;
         if (i == 3) chk("fill_full_pre", full_o, 0);
         step();
      end
      req_hs_i = 1'b0; #1;
      chk("fill_full", full_o, 1);
      chk("fill_head", rsp_idx_o, 1);
      rsp_valid_i = 1'b1; #1;
      chk("full_pop_valid", rsp_valid_o, 4'b0010);
      step();
      rsp_valid_i = 1'b0; #1;
      chk("after_pop_full", full_o, 0);
      chk("after_pop_head", rsp_idx_o, 2);
      step();
      req_hs_i = 1'b1; req_idx_i = 2'd1; rsp_valid_i = 1'b1; #1;
      chk("pushpop_valid", rsp_valid_o, 4'b0100);
      step();
      req_hs_i = 1'b0; rsp_valid_i = 1'b0; #1;
      chk("pushpop_full", full_o, 0);
      chk("pushpop_head", rsp_idx_o, 3);
      step();
      req_hs_i = 1'b1; req_idx_i = 2'd2; #1;
      step();
      req_hs_i = 1'b0; #1;
      chk("cnt3_refill_full", full_o, 1);
      rsp_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         exp_v = 4'b0001 << drain[i];
         chk("drain_valid", rsp_valid_o, exp_v);
         step();
      end
      rsp_valid_i = 1'b0; #1;
      chk("drain_busy", busy_o, 0);

      // Pointer wrap with one entry kept in flight
      req_hs_i = 1'b1; req_idx_i = seq[0]; #1;
      step();
      for (int i = 1; i < 11; i++) begin
         req_idx_i = seq[i]; rsp_valid_i = 1'b1; #1;
         exp_v = 4'b0001 << seq[i-1];
         chk("wrap_valid", rsp_valid_o, exp_v);
         step();
      end
      req_hs_i = 1'b0; #1;
      exp_v = 4'b0001 << seq[10];
      chk("wrap_last", rsp_valid_o, exp_v);
      step();
      rsp_valid_i = 1'b0; #1;
      chk("wrap_busy", busy_o, 0);

      // Multi-beat response with ready toggling 1,0,1,1
      req_hs_i = 1'b1; req_idx_i = 2'd1; #1;
      step();
      req_hs_i = 1'b0; rsp_valid_i = 1'b1; rsp_last_i = 1'b0;
      rsp_ready_i = 4'b0010; rsp_data_i = 32'hb0; #1;
      chk("mb0_ready", rsp_ready_o, 1);
      chk("mb0_valid", rsp_valid_o, 4'b0010);
      step();
      rsp_ready_i = 4'b0000; rsp_data_i = 32'hb1; #1;
      chk("mb1_ready", rsp_ready_o, 0);
      chk("mb1_idx", rsp_idx_o, 1);
      step();
      rsp_ready_i = 4'b0010; #1;
      chk("mb1r_ready", rsp_ready_o, 1);
      chk("mb1r_busy", busy_o, 1);
      step();
      rsp_last_i = 1'b1; rsp_data_i = 32'hb2; #1;
      chk("mb2_idx", rsp_idx_o, 1);
      chk("mb2_last", rsp_last_o, 1);
      chk("mb2_busy", busy_o, 1);
      step();
      rsp_valid_i = 1'b0; rsp_last_i = 1'b0; #1;
      chk("mb_done_busy", busy_o, 0);

      // Response stalled while empty
      rsp_ready_i = 4'hf; rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", rsp_ready_o, 0);
         chk("stall_valid", rsp_valid_o, 0);
         step();
      end
      req_hs_i = 1'b1; req_idx_i = 2'd2; #1;
      chk("stall_push_ready", rsp_ready_o, 0);
      step();
      req_hs_i = 1'b0; #1;
      chk("stall_served_valid", rsp_valid_o, 4'b0100);
      chk("stall_served_ready", rsp_ready_o, 1);
      step();
      rsp_valid_i = 1'b0; #1;
      chk("stall_done_busy", busy_o, 0);

      // Flush overrides a same-cycle push
      req_hs_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_idx_i = 2'(i); #1;
         step();
      end
      req_idx_i = 2'd3; flush_i = 1'b1; #1;
      step();
      flush_i = 1'b0; req_hs_i = 1'b0; #1;
      chk("flush_busy", busy_o, 0);
      chk("flush_full", full_o, 0);
      step();
      req_hs_i = 1'b1; req_idx_i = 2'd3; #1;
      step();
      req_hs_i = 1'b0; rsp_valid_i = 1'b1; rsp_last_i = 1'b1; #1;
      chk("post_flush_valid", rsp_valid_o, 4'b1000);
      chk("post_flush_idx", rsp_idx_o, 3);
      step();
      rsp_valid_i = 1'b0; #1;
      chk("post_flush_busy", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
